// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte producers
//
// Purpose:
//   Grants one requester at a time, hands its byte to the UART transmitter with a
//   one-cycle start pulse, and acks the requester on the transmitter's done tick.
//   A requester that leaves last low keeps ownership for its next byte. Ownership
//   is released if the owner stays silent for LOCK_TIMEOUT cycles.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   req_i          per-requester request, held with data valid until acked
//   last_i         per-requester end-of-message flag, qualified with req_i
//   data_i         requester i's byte on bits [i*DATA_W +: DATA_W]
//   ack_o          one-cycle pulse to the owner when its byte has been sent
//   tx_start_o     one-cycle start pulse to the transmitter
//   tx_data_o      registered byte to transmit
//   tx_done_tick_i end-of-stop-bit pulse from the transmitter
//   busy_o         high whenever the arbiter is not idle
//   owner_o        index of the current or last granted requester
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int OW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int TW          = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          last_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic                        tx_start_o,
    output logic [DATA_W-1:0]           tx_data_o,
    input  logic                        tx_done_tick_i,
    output logic                        busy_o,
    output logic [OW-1:0]               owner_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_LOCKED
    } state_t;

    localparam logic [TW-1:0] TIMER_MAX  = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [OW-1:0] OWNER_TOP  = OW'(NUM_REQ - 1);

    state_t              state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                last_q, last_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic                grant_found;
    logic [OW-1:0]       grant_idx;
    logic [OW-1:0]       cand;
    logic [OW-1:0]       next_ptr;
    logic [TW-1:0]       timer_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = data_i[g*DATA_W +: DATA_W];
    end

    // First set request scanning upward from ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = OW'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign next_ptr  = (owner_q == OWNER_TOP) ? '0 : owner_q + OW'(1);
    // Saturating increment; the release test uses the incremented value so the
    // arbiter is back in IDLE LOCK_TIMEOUT cycles after the ack cycle.
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    owner_d   = grant_idx;
                    tx_data_d = data_arr[grant_idx];
                    last_d    = last_i[grant_idx];
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_tick_i) begin
                    if (last_q) begin
                        ptr_d   = next_ptr;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                // A request from the owner beats a timeout in the same cycle.
                if (req_i[owner_q]) begin
                    tx_data_d = data_arr[owner_q];
                    last_d    = last_i[owner_q];
                    state_d   = S_START;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc >= TIMER_LAST) begin
                        ptr_d   = next_ptr;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ack_o = '0;
        if (state_q == S_WAIT && tx_done_tick_i) begin
            ack_o[owner_q] = 1'b1;
        end
    end

    assign tx_start_o = (state_q == S_START);
    assign busy_o     = (state_q != S_IDLE);
    assign tx_data_o  = tx_data_q;
    assign owner_o    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        done;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .DATA_W       (8),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_i          (req),
        .last_i         (last),
        .data_i         (data),
        .ack_o          (ack),
        .tx_start_o     (tx_start),
        .tx_data_o      (tx_data),
        .tx_done_tick_i (done),
        .busy_o         (busy),
        .owner_o        (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [31:0] data;
        logic        done;
        logic        exp_start;
        logic [3:0]  exp_ack;
        logic        exp_busy;
        logic [1:0]  exp_owner;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                           input logic dn, input logic s, input logic [3:0] a,
                           input logic b, input logic [1:0] o, input logic [7:0] t);
        vec_t v;
        v.req = r; v.last = l; v.data = d; v.done = dn;
        v.exp_start = s; v.exp_ack = a; v.exp_busy = b; v.exp_owner = o; v.exp_txd = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        last  = '0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_start(input int own);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        check($sformatf("grant %0d seen", own), 32'(seen), 32'd1);
        check($sformatf("grant %0d owner", own), 32'(owner), own);
    endtask

    task automatic finish_byte(input int own);
        next_cycle();
        next_cycle();
        done = 1'b1;
        #1;
        check($sformatf("ack %0d", own), 32'(ack), 32'd1 << own);
        next_cycle();
        done = 1'b0;
        req[own] = 1'b0;
    endtask

    initial begin
        data = 32'h3020B110;

        // Reset state
        do_reset();
        reset = 1'b1;
        req = 4'b1111;
        last = 4'b1111;
        #2;
        check("reset busy", 32'(busy), 0);
        check("reset start", 32'(tx_start), 0);
        check("reset ack", 32'(ack), 0);
        check("reset owner", 32'(owner), 0);
        check("reset txd", 32'(tx_data), 0);

        // Table: requester 0 single byte, requester 1 locked 3-byte message with
        // 0 and 2 waiting, then 2 before 0, spurious done in IDLE and START.
        add_vec(4'b0001, 4'b0001, 32'h3020B110, 0, 0, 4'b0000, 0, 0, 8'h00);
        add_vec(4'b0001, 4'b0001, 32'h3020B110, 0, 1, 4'b0000, 1, 0, 8'h10);
        add_vec(4'b0001, 4'b0001, 32'h3020B110, 1, 0, 4'b0001, 1, 0, 8'h10);
        add_vec(4'b0111, 4'b0101, 32'h3020B110, 0, 0, 4'b0000, 0, 0, 8'h10);
        add_vec(4'b0111, 4'b0101, 32'h3020B110, 0, 1, 4'b0000, 1, 1, 8'hB1);
        add_vec(4'b0111, 4'b0101, 32'h3020B110, 1, 0, 4'b0010, 1, 1, 8'hB1);
        add_vec(4'b0111, 4'b0101, 32'h3020B210, 0, 0, 4'b0000, 1, 1, 8'hB1);
        add_vec(4'b0111, 4'b0101, 32'h3020B210, 0, 1, 4'b0000, 1, 1, 8'hB2);
        add_vec(4'b0111, 4'b0101, 32'h3020B210, 0, 0, 4'b0000, 1, 1, 8'hB2);
        add_vec(4'b0111, 4'b0101, 32'h3020B210, 1, 0, 4'b0010, 1, 1, 8'hB2);
        add_vec(4'b0111, 4'b0111, 32'h3020B310, 0, 0, 4'b0000, 1, 1, 8'hB2);
        add_vec(4'b0111, 4'b0111, 32'h3020B310, 0, 1, 4'b0000, 1, 1, 8'hB3);
        add_vec(4'b0111, 4'b0111, 32'h3020B310, 1, 0, 4'b0010, 1, 1, 8'hB3);
        add_vec(4'b0101, 4'b0111, 32'h3020B310, 0, 0, 4'b0000, 0, 1, 8'hB3);
        add_vec(4'b0101, 4'b0111, 32'h3020B310, 0, 1, 4'b0000, 1, 2, 8'h20);
        add_vec(4'b0101, 4'b0111, 32'h3020B310, 1, 0, 4'b0100, 1, 2, 8'h20);
        add_vec(4'b0001, 4'b0111, 32'h3020B310, 1, 0, 4'b0000, 0, 2, 8'h20);
        add_vec(4'b0001, 4'b0111, 32'h3020B310, 1, 1, 4'b0000, 1, 0, 8'h10);
        add_vec(4'b0001, 4'b0111, 32'h3020B310, 0, 0, 4'b0000, 1, 0, 8'h10);
        add_vec(4'b0001, 4'b0111, 32'h3020B310, 1, 0, 4'b0001, 1, 0, 8'h10);
        add_vec(4'b0000, 4'b0111, 32'h3020B310, 0, 0, 4'b0000, 0, 0, 8'h10);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            last = vecs[i].last;
            data = vecs[i].data;
            done = vecs[i].done;
            #2;
            check($sformatf("vec%0d start", i), 32'(tx_start), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].exp_owner));
            check($sformatf("vec%0d txd", i), 32'(tx_data), 32'(vecs[i].exp_txd));
            next_cycle();
        end

        // Single byte with exact cycle numbers; cycle 22 proves ptr moved to 3.
        do_reset();
        data = 32'h3041B110;
        for (int c = 0; c <= 22; c++) begin
            done = (c == 20);
            if (c < 5) begin
                req = 4'b0000; last = 4'b0000;
            end else if (c <= 20) begin
                req = 4'b0100; last = 4'b0100;
            end else begin
                req = 4'b1001; last = 4'b1001;
            end
            #2;
            if (c == 5) begin
                check("single c5 start", 32'(tx_start), 0);
                check("single c5 busy", 32'(busy), 0);
            end
            if (c == 6) begin
                check("single c6 start", 32'(tx_start), 1);
                check("single c6 txd", 32'(tx_data), 32'h41);
                check("single c6 owner", 32'(owner), 2);
            end
            if (c == 7) check("single c7 start", 32'(tx_start), 0);
            if (c == 19) begin
                check("single c19 ack", 32'(ack), 0);
                check("single c19 busy", 32'(busy), 1);
            end
            if (c == 20) check("single c20 ack", 32'(ack), 32'b0100);
            if (c == 21) begin
                check("single c21 busy", 32'(busy), 0);
                check("single c21 ack", 32'(ack), 0);
            end
            if (c == 22) begin
                check("single c22 start", 32'(tx_start), 1);
                check("single c22 owner", 32'(owner), 3);
            end
            next_cycle();
        end
        data = 32'h3020B110;

        // Round robin after reset
        do_reset();
        req = 4'b1011;
        last = 4'b1111;
        wait_start(0);
        finish_byte(0);
        req[0] = 1'b1;
        wait_start(1);
        finish_byte(1);
        wait_start(3);
        finish_byte(3);
        wait_start(0);
        finish_byte(0);

        // Lock timeout
        do_reset();
        req = 4'b1001;
        last = 4'b1000;
        wait_start(0);
        next_cycle();
        next_cycle();
        done = 1'b1;
        #1;
        check("lock ack", 32'(ack), 32'b0001);
        next_cycle();
        done = 1'b0;
        req[0] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            #1;
            check($sformatf("lock busy k+%0d", j), 32'(busy), (j < 8) ? 32'd1 : 32'd0);
            next_cycle();
        end
        #1;
        check("timeout next start", 32'(tx_start), 1);
        check("timeout next owner", 32'(owner), 3);
        finish_byte(3);
        req[1] = 1'b1;
        last[1] = 1'b1;
        wait_start(1);
        finish_byte(1);

        // Reset mid-WAIT with ptr at 2 beforehand
        do_reset();
        req = 4'b0010;
        last = 4'b0010;
        wait_start(1);
        finish_byte(1);
        req = 4'b1000;
        last = 4'b1000;
        wait_start(3);
        next_cycle();
        done = 1'b1;
        req = 4'b1010;
        last = 4'b1010;
        #1;
        reset = 1'b1;
        #1;
        check("rst wait ack", 32'(ack), 0);
        check("rst wait busy", 32'(busy), 0);
        check("rst wait start", 32'(tx_start), 0);
        check("rst wait owner", 32'(owner), 0);
        check("rst wait txd", 32'(tx_data), 0);
        next_cycle();
        reset = 1'b0;
        done = 1'b0;
        wait_start(1);
        finish_byte(1);
        wait_start(3);
        finish_byte(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
